cordic_rotation_stage: RTL and testbench
========================================

Name: cordic_rotation_stage

Overview:
One iteration of a fully unrolled, rotation-mode CORDIC pipeline that computes cosine.
- Sixteen instances are chained, with stage i using shift i and shift_angle = atan(2^-i).
- The first stage is fed x = K ≈ 0.607253 (0x09B74E), y = 0 and angle = 0.
- The last stage's new_x is cos(target).
- Each stage does one conditional micro-rotation and forwards target, with one clock of latency.

Parameters:
- DATA_WIDTH, 22, total width of the signed two's-complement fixed-point word.
- FRACTIONAL_WIDTH, 20, number of fractional bits. Format is Q2.20, so 1.0 = 0x100000.
- SHIFT_WIDTH, 4, width of shift_value.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- clk_en  in  1  stage enable. When low, all registers hold.
- target  in  22  signed target angle, radians.
- shift_value  in  4  iteration index i, range 0..15.
- shift_angle  in  22  unsigned constant atan(2^-i), radians.
- angle  in  22  signed accumulated angle z.
- x  in  22  signed x.
- y  in  22  signed y.
- new_angle  out  22  registered signed updated angle.
- new_x  out  22  registered signed updated x.
- new_y  out  22  registered signed updated y.
- target_out  out  22  registered copy of target.

Behaviour:
- Reset: rst low clears new_x, new_y, new_angle and target_out to 0 immediately, without waiting for a clock edge.
- Reset release is synchronous to the next rising edge, which resumes normal operation.
- All four outputs are registers updated only on a rising clk edge with rst high and clk_en high. Latency is exactly 1 cycle. Throughput is one sample per cycle; there is no handshake.
- clk_en low: all outputs hold their previous values.
- Direction select: d = +1 when signed(angle) <= signed(target), otherwise d = -1. Equality takes the positive direction.
- xs = x >>> shift_value and ys = y >>> shift_value. Both are arithmetic (sign-extending) right shifts; shift_value = 0 passes the operand through.
- Update for d = +1:
  - new_x = x - ys
  - new_y = y + xs
  - new_angle = angle + shift_angle
- Update for d = -1:
  - new_x = x + ys
  - new_y = y - xs
  - new_angle = angle - shift_angle
- Width: all arithmetic is at 22 bits. Results truncate to 22 bits (two's-complement wrap), with no saturation and no overflow flag.
- Decision inputs: angle, target, x and y are all sampled at the same edge, so the direction is decided from the current inputs, not from registered state.
- target_out is target delayed by 1 cycle, under the same clk_en and rst rules.
- Boundaries:
  - shift_value 15 on a small magnitude yields 0 or -1 LSB; sign extension is required.
  - rst asserted mid-stream discards the in-flight sample.
  - Inputs changing while clk_en is low have no effect.

Test Plan:
1. Reset, then positive rotation. Hold rst low: all outputs are 0 without a clock edge. Release rst and apply clk_en=1, shift_value=0, shift_angle=0x0C90FD, x=0x09B74E, y=0, angle=0, target=0x0C90FD. After one edge, the response is new_x=0x09B74E, new_y=0x09B74E, new_angle=0x0C90FD, target_out=0x0C90FD.
2. Negative rotation. Same inputs with target=0x3F0000 (negative). Response is new_x=0x09B74E, new_y=0x3648B2, new_angle=0x336F03, target_out=0x3F0000.
3. Shift, positive direction. shift_value=1, shift_angle=0x076B19, x=0x100000, y=0x080000, angle=0, target=0x010000. Response is new_x=0x0C0000, new_y=0x100000, new_angle=0x076B19.
4. Arithmetic shift of a negative operand. shift_value=2, shift_angle=0x03EB6E, x=0x100000, y=0x3C0000, angle=0, target=0x3FFFFF. This gives d = -1. Response is new_x=0x0F0000, new_y=0x380000, new_angle=0x3C1492.
5. Enable and reset priority.
   - After loading a value, drop clk_en and change every input: outputs hold for 3 cycles.
   - Pulse rst low between clock edges: outputs clear immediately.
6. Chain check. Build a 16-stage chain with shifts 0..15 and atan constants 0x0C90FD, 0x076B19, 0x03EB6E, …, 0x00001F. Feed x=0x09B74E, y=0, angle=0.
   - target=0: final new_x ≈ 0x100000 within ±0x40, valid 16 cycles later.
   - target=0x0C90FD: final new_x ≈ 0x0B504F within ±0x40.

Source files
------------

// File: rtl/cordic_rotation_stage.sv
// One rotation-mode CORDIC micro-rotation with a single register stage.
// Sixteen of these chained (shift i, shift_angle = atan(2^-i)) and seeded
// with x = K, y = 0, angle = 0 produce cos(target) on the last new_x.
module cordic_rotation_stage #(
  parameter int DATA_WIDTH       = 22,
  parameter int FRACTIONAL_WIDTH = 20,
  parameter int SHIFT_WIDTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic signed [DATA_WIDTH-1:0] target,
  input  logic [SHIFT_WIDTH-1:0]       shift_value,
  input  logic [DATA_WIDTH-1:0]        shift_angle,
  input  logic signed [DATA_WIDTH-1:0] angle,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] y,
  output logic signed [DATA_WIDTH-1:0] new_angle,
  output logic signed [DATA_WIDTH-1:0] new_x,
  output logic signed [DATA_WIDTH-1:0] new_y,
  output logic signed [DATA_WIDTH-1:0] target_out
);

  // Fixed-point format needs at least one integer bit besides the sign.
  if (FRACTIONAL_WIDTH > DATA_WIDTH - 2) begin : g_fmt_chk
    $error("cordic_rotation_stage: FRACTIONAL_WIDTH leaves no integer bit");
  end

  // Registered stage result, one word per output.
  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] x;
    logic signed [DATA_WIDTH-1:0] y;
    logic signed [DATA_WIDTH-1:0] angle;
    logic signed [DATA_WIDTH-1:0] target;
  } stage_word_t;

  stage_word_t                  nxt_w;
  stage_word_t                  q_w;
  logic                         rot_pos;
  logic signed [DATA_WIDTH-1:0] xs;
  logic signed [DATA_WIDTH-1:0] ys;
  logic signed [DATA_WIDTH-1:0] step_ang;

  // Micro-rotation: pick direction from the live inputs, shift
  // arithmetically, and add/subtract at full word width (wraps on overflow).
  always_comb begin
    rot_pos  = (angle <= target);    // tie rotates positive
    xs       = x >>> shift_value;
    ys       = y >>> shift_value;
    step_ang = $signed(shift_angle); // bit pattern reused; only add/sub follows
    nxt_w    = '0;
    nxt_w.target = target;
    if (rot_pos) begin
      nxt_w.x     = x - ys;
      nxt_w.y     = y + xs;
      nxt_w.angle = angle + step_ang;
    end else begin
      nxt_w.x     = x + ys;
      nxt_w.y     = y - xs;
      nxt_w.angle = angle - step_ang;
    end
  end

  // Output register: async clear, loads only when the stage is enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        q_w <= '0;
    else if (clk_en) q_w <= nxt_w;
  end

  assign new_x      = q_w.x;
  assign new_y      = q_w.y;
  assign new_angle  = q_w.angle;
  assign target_out = q_w.target;

endmodule

// File: tb/tb_cordic_rotation_stage.sv
// Directed checks of one CORDIC stage plus a 16-stage cosine chain.
module tb_cordic_rotation_stage;

  localparam int DW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic [DW-1:0] target, shift_angle, angle, x, y;
  logic [3:0]    shift_value;
  logic [DW-1:0] new_angle, new_x, new_y, target_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic_rotation_stage #(.DATA_WIDTH(DW), .FRACTIONAL_WIDTH(20), .SHIFT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .target(target),
    .shift_value(shift_value), .shift_angle(shift_angle), .angle(angle),
    .x(x), .y(y), .new_angle(new_angle), .new_x(new_x), .new_y(new_y),
    .target_out(target_out)
  );

  // ---------------- 16-stage chain ----------------
  localparam logic [DW-1:0] ATAN [16] = '{
    22'h0C90FD, 22'h076B19, 22'h03EB6E, 22'h01FD5B,
    22'h00FFAA, 22'h007FF5, 22'h003FFE, 22'h001FFF,
    22'h000FFF, 22'h0007FF, 22'h0003FF, 22'h0001FF,
    22'h0000FF, 22'h00007F, 22'h00003F, 22'h00001F
  };

  logic [DW-1:0] chain_target;
  logic [DW-1:0] cx [17];
  logic [DW-1:0] cy [17];
  logic [DW-1:0] ca [17];
  logic [DW-1:0] ct [17];

  assign cx[0] = 22'h09B74E;
  assign cy[0] = '0;
  assign ca[0] = '0;
  assign ct[0] = chain_target;

  for (genvar g = 0; g < 16; g++) begin : g_chain
    cordic_rotation_stage #(.DATA_WIDTH(DW), .FRACTIONAL_WIDTH(20), .SHIFT_WIDTH(4)) u_stg (
      .clk(clk), .rst(rst), .clk_en(1'b1), .target(ct[g]),
      .shift_value(4'(g)), .shift_angle(ATAN[g]), .angle(ca[g]),
      .x(cx[g]), .y(cy[g]), .new_angle(ca[g+1]), .new_x(cx[g+1]),
      .new_y(cy[g+1]), .target_out(ct[g+1])
    );
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] sv, input logic [DW-1:0] sa,
                       input logic [DW-1:0] xi, input logic [DW-1:0] yi,
                       input logic [DW-1:0] ai, input logic [DW-1:0] ti);
    shift_value = sv; shift_angle = sa; x = xi; y = yi; angle = ai; target = ti;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [DW-1:0] ex, input logic [DW-1:0] ey,
                      input logic [DW-1:0] ea, input logic [DW-1:0] et);
    chk({tag, ".x"}, new_x, ex);
    chk({tag, ".y"}, new_y, ey);
    chk({tag, ".angle"}, new_angle, ea);
    chk({tag, ".target"}, target_out, et);
  endtask

  task automatic chk_near(input string tag, input logic [DW-1:0] obs,
                          input logic [DW-1:0] exp, input int tol);
    int diff;
    diff = int'($signed(obs)) - int'($signed(exp));
    n_cmp++;
    assert (diff >= -tol && diff <= tol) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h +/- %0h", tag, obs, exp, tol);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0; clk_en = 1'b0; chain_target = '0;
    drive(4'd0, '0, '0, '0, '0, '0);
    #2;
    chk4("reset", '0, '0, '0, '0);

    @(posedge clk); #1;
    rst = 1'b1; clk_en = 1'b1;

    // positive rotation, shift 0
    drive(4'd0, 22'h0C90FD, 22'h09B74E, '0, '0, 22'h0C90FD);
    step();
    chk4("pos_rot", 22'h09B74E, 22'h09B74E, 22'h0C90FD, 22'h0C90FD);

    // negative rotation: target below angle
    target = 22'h3F0000;
    step();
    chk4("neg_rot", 22'h09B74E, 22'h3648B2, 22'h336F03, 22'h3F0000);

    // shift 1, positive direction
    drive(4'd1, 22'h076B19, 22'h100000, 22'h080000, '0, 22'h010000);
    step();
    chk4("shift1", 22'h0C0000, 22'h100000, 22'h076B19, 22'h010000);

    // negative y with arithmetic shift 2, target -1 LSB forces d = -1
    drive(4'd2, 22'h03EB6E, 22'h100000, 22'h3C0000, '0, 22'h3FFFFF);
    step();
    chk4("ashift2", 22'h0F0000, 22'h380000, 22'h3C1492, 22'h3FFFFF);

    // shift 15 on small values: ys must be -1, xs 0
    drive(4'd15, 22'h00001F, 22'h000005, 22'h3FFFFB, '0, '0);
    step();
    chk4("shift15", 22'h000006, 22'h3FFFFB, 22'h00001F, 22'h000000);

    // angle == target (both positive) rotates positive
    drive(4'd0, 22'h0C90FD, 22'h010000, 22'h020000, 22'h100000, 22'h100000);
    step();
    chk4("tie", 22'h3F0000, 22'h030000, 22'h1C90FD, 22'h100000);

    // angle sum wraps into the negative range
    drive(4'd0, 22'h0C90FD, '0, '0, 22'h1F0000, 22'h1FFFFF);
    step();
    chk("wrap.angle", new_angle, 22'h2B90FD);

    // reload shift-1 case, then freeze with clk_en low and scramble inputs
    drive(4'd1, 22'h076B19, 22'h100000, 22'h080000, '0, 22'h010000);
    step();
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'(i + 3), 22'h012345 + 22'(i), 22'h2AAAAA, 22'h155555, 22'h3ABCDE, 22'h2FFFFF);
      step();
      chk4("hold", 22'h0C0000, 22'h100000, 22'h076B19, 22'h010000);
    end

    // async reset between edges clears immediately
    rst = 1'b0;
    #2;
    chk4("mid_rst", '0, '0, '0, '0);
    #1 rst = 1'b1;
    step();
    chk("rst_then_hold.x", new_x, 22'h000000);

    // resume normal operation after reset
    clk_en = 1'b1;
    drive(4'd0, 22'h0C90FD, 22'h09B74E, '0, '0, 22'h0C90FD);
    step();
    chk4("resume", 22'h09B74E, 22'h09B74E, 22'h0C90FD, 22'h0C90FD);

    // cosine chain: cos(0) then cos(pi/4)
    chain_target = '0;
    repeat (16) step();
    chk_near("chain_cos0", cx[16], 22'h100000, 'h40);
    chk("chain_tgt0", ct[16], 22'h000000);

    chain_target = 22'h0C90FD;
    repeat (16) step();
    chk_near("chain_cos_pi4", cx[16], 22'h0B504F, 'h40);
    chk("chain_tgt_pi4", ct[16], 22'h0C90FD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
